// File: rtl/pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_sequencer
// Purpose  : Stall/flush/halt controller for the five-stage IF-ID-EX-MA-WB
//            pipeline, with memory-wait watchdog and stall-cycle counter.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_sequencer #(
    parameter int         REG_AW      = 4,
    parameter int         MEM_TIMEOUT = 15,
    parameter logic [4:0] HLT_OPCODE  = 5'b11111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_need_rs1,
    input  logic              id_need_rs2,
    input  logic              ex_mem_en,
    input  logic              ex_mem_wr,
    input  logic              ex_reg_we,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_redirect,
    input  logic              ma_mem_en,
    input  logic              dmem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exma_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              mawb_bubble,
    output logic              halted,
    output logic              mem_err,
    output logic [15:0]       stall_cycles
);

    localparam logic [1:0] c_ST_RUN    = 2'd0;
    localparam logic [1:0] c_ST_DRAIN  = 2'd1;
    localparam logic [1:0] c_ST_HALTED = 2'd2;

    localparam int                    c_WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0]   c_WAIT_MAX  = c_WAIT_W'(MEM_TIMEOUT);
    localparam logic [c_WAIT_W-1:0]   c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [1:0]          r_drain_cnt;
    logic [1:0]          w_drain_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_mem_err;
    logic [15:0]         r_stall_cnt;

    logic w_mem_wait;
    logic w_load_use;
    logic w_is_hlt;
    logic w_timeout;

    assign w_mem_wait = ma_mem_en & ~dmem_ready;
    assign w_load_use = (ex_mem_en & ~ex_mem_wr & ex_reg_we) &
                        ((id_need_rs1 && (id_rs1 == ex_rd)) ||
                         (id_need_rs2 && (id_rs2 == ex_rd)));
    assign w_is_hlt   = (id_opcode == HLT_OPCODE);
    // The watchdog trips on the edge where the wait count would reach the limit.
    assign w_timeout  = w_mem_wait && (r_wait_cnt == c_WAIT_LAST);

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exma_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        mawb_bubble = 1'b0;
        halted      = 1'b0;
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;

        case (r_state)
            c_ST_RUN, c_ST_DRAIN: begin
                if (w_mem_wait) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exma_en     = 1'b0;
                    mawb_bubble = 1'b1;
                end else if (r_state == c_ST_DRAIN) begin
                    pc_en       = 1'b0;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    w_drain_nxt = r_drain_cnt - 2'd1;
                    if (r_drain_cnt == 2'd1) begin
                        w_state_nxt = c_ST_HALTED;
                    end
                end else if (ex_redirect) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (w_load_use) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                end else if (w_is_hlt) begin
                    pc_en       = 1'b0;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    w_state_nxt = c_ST_DRAIN;
                    w_drain_nxt = 2'd3;
                end
            end
            c_ST_HALTED: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exma_en     = 1'b0;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                mawb_bubble = 1'b1;
                halted      = 1'b1;
            end
            default: w_state_nxt = c_ST_RUN;
        endcase

        if (w_timeout) begin
            w_state_nxt = c_ST_HALTED;
        end

        // Hold every stage quiet for as long as reset is asserted.
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exma_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            mawb_bubble = 1'b1;
            halted      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_RUN;
            r_drain_cnt <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            if (!w_mem_wait) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != c_WAIT_MAX) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
        end else if (!pc_en && (r_state != c_ST_HALTED) && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign mem_err      = r_mem_err;
    assign stall_cycles = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_sequencer
// Purpose  : Directed plus randomized self-checking bench for
//            pipeline_sequencer against a behavioural reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_sequencer;

    localparam int         REG_AW      = 4;
    localparam int         MEM_TIMEOUT = 15;
    localparam logic [4:0] HLT         = 5'b11111;

    logic              clk = 1'b0;
    logic              rst;
    logic [4:0]        id_opcode;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
    logic              id_need_rs1, id_need_rs2;
    logic              ex_mem_en, ex_mem_wr, ex_reg_we, ex_redirect;
    logic              ma_mem_en, dmem_ready;
    logic              pc_en, ifid_en, idex_en, exma_en;
    logic              ifid_flush, idex_bubble, mawb_bubble, halted, mem_err;
    logic [15:0]       stall_cycles;
    logic [7:0]        ctl;

    pipeline_sequencer #(
        .REG_AW(REG_AW), .MEM_TIMEOUT(MEM_TIMEOUT), .HLT_OPCODE(HLT)
    ) dut (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_need_rs1(id_need_rs1), .id_need_rs2(id_need_rs2),
        .ex_mem_en(ex_mem_en), .ex_mem_wr(ex_mem_wr), .ex_reg_we(ex_reg_we), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect), .ma_mem_en(ma_mem_en), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exma_en(exma_en),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .mawb_bubble(mawb_bubble),
        .halted(halted), .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    assign ctl = {pc_en, ifid_en, idex_en, exma_en, ifid_flush, idex_bubble, mawb_bubble, halted};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pipeline status as plain flags and integer counts.
    bit         m_halted, m_draining, m_err;
    int         m_drain_left, m_waits, m_stall;
    logic [7:0] e_ctl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit f_mem_wait();
        return ma_mem_en && !dmem_ready;
    endfunction

    function automatic bit f_load_use();
        return ex_mem_en && !ex_mem_wr && ex_reg_we &&
               ((id_need_rs1 && id_rs1 == ex_rd) || (id_need_rs2 && id_rs2 == ex_rd));
    endfunction

    task automatic predict();
        if (rst)                  e_ctl = 8'b0000_1110;
        else if (m_halted)        e_ctl = 8'b0000_1111;
        else if (f_mem_wait())    e_ctl = 8'b0000_0010;
        else if (m_draining)      e_ctl = 8'b0111_1100;
        else if (ex_redirect)     e_ctl = 8'b1111_1100;
        else if (f_load_use())    e_ctl = 8'b0011_0100;
        else if (id_opcode == HLT) e_ctl = 8'b0111_1100;
        else                      e_ctl = 8'b1111_0000;
    endtask

    task automatic model_clock();
        bit mw, was_halted;
        mw = f_mem_wait();
        was_halted = m_halted;
        if (!e_ctl[7] && !was_halted && m_stall < 65535) m_stall++;
        if (!was_halted && !mw) begin
            if (m_draining) begin
                m_drain_left--;
                if (m_drain_left == 0) m_halted = 1;
            end else if (!ex_redirect && !f_load_use() && id_opcode == HLT) begin
                m_draining   = 1;
                m_drain_left = 3;
            end
        end
        if (mw) begin
            if (m_waits + 1 == MEM_TIMEOUT) begin
                m_err    = 1;
                m_halted = 1;
            end
            if (m_waits < MEM_TIMEOUT) m_waits++;
        end else begin
            m_waits = 0;
        end
    endtask

    task automatic step(input string tag, input bit do_chk);
        #4;
        predict();
        if (do_chk) begin
            chk({tag, "_ctl"}, ctl, e_ctl);
            chk({tag, "_stall"}, stall_cycles, m_stall);
            chk({tag, "_err"}, mem_err, m_err);
        end
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic set_idle();
        id_opcode = 5'd0; id_rs1 = '0; id_rs2 = '0; id_need_rs1 = 0; id_need_rs2 = 0;
        ex_mem_en = 0; ex_mem_wr = 0; ex_reg_we = 0; ex_rd = '0; ex_redirect = 0;
        ma_mem_en = 0; dmem_ready = 1;
    endtask

    task automatic set_load_use();
        ex_mem_en = 1; ex_mem_wr = 0; ex_reg_we = 1; ex_rd = 4'd3;
        id_opcode = 5'd1; id_need_rs1 = 1; id_rs1 = 4'd3;
    endtask

    // Reset is raised mid-cycle so its effect must be visible before any edge.
    task automatic do_reset();
        rst = 1;
        #1;
        chk("rst_ctl", ctl, 8'b0000_1110);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_err", mem_err, 0);
        m_halted = 0; m_draining = 0; m_err = 0; m_drain_left = 0; m_waits = 0; m_stall = 0;
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        set_idle();
        rst = 1;
        #1;
        @(posedge clk);
        #1;
        do_reset();

        step("normal", 1);
        chk("normal_first", ctl, 8'b1111_0000);

        // Load-use: one bubble then normal flow.
        set_load_use();
        step("lu_stall", 1);
        set_idle();
        step("lu_after", 1);
        chk("lu_stall_cnt", stall_cycles, 1);
        set_load_use();
        id_need_rs1 = 0;
        step("lu_noneed", 1);
        chk("lu_noneed_cnt", stall_cycles, 1);

        // Redirect outranks load-use and halt.
        set_load_use();
        id_opcode = HLT;
        ex_redirect = 1;
        #4;
        chk("redir_ctl", ctl, 8'b1111_1100);
        @(posedge clk);
        predict();
        model_clock();
        #1;
        set_idle();
        step("redir_after", 1);
        chk("redir_halted", halted, 0);

        // Four-cycle memory wait.
        do_reset();
        ma_mem_en = 1; dmem_ready = 0;
        for (int i = 0; i < 4; i++) step("mwait", 1);
        dmem_ready = 1;
        step("mwait_rel", 1);
        chk("mwait_stall", stall_cycles, 4);
        chk("mwait_err", mem_err, 0);

        // Watchdog timeout.
        do_reset();
        ma_mem_en = 1; dmem_ready = 0;
        for (int i = 0; i < MEM_TIMEOUT; i++) step("wdog", 1);
        chk("wdog_err", mem_err, 1);
        chk("wdog_halted", halted, 1);
        set_idle();
        for (int i = 0; i < 3; i++) step("wdog_hold", 1);
        chk("wdog_err_sticky", mem_err, 1);
        do_reset();
        chk("wdog_clr_halted", halted, 0);

        // Halt drain without and with a mem_wait cycle.
        id_opcode = HLT;
        step("hlt0", 1);
        set_idle();
        for (int k = 1; k <= 5; k++) begin
            chk("hlt_timing", halted, (k >= 4) ? 1 : 0);
            step("hlt_drain", 1);
        end
        do_reset();
        id_opcode = HLT;
        step("hltw0", 1);
        set_idle();
        for (int k = 1; k <= 7; k++) begin
            chk("hltw_timing", halted, (k >= 5) ? 1 : 0);
            ma_mem_en = (k == 2); dmem_ready = (k != 2);
            step("hltw_drain", 1);
            set_idle();
        end
        chk("hltw_stall", stall_cycles, 5);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            id_opcode   = ($urandom_range(0, 19) == 0) ? HLT : 5'($urandom_range(0, 30));
            id_rs1      = 4'($urandom_range(0, 3));
            id_rs2      = 4'($urandom_range(0, 3));
            id_need_rs1 = 1'($urandom);
            id_need_rs2 = 1'($urandom);
            ex_mem_en   = 1'($urandom);
            ex_mem_wr   = 1'($urandom);
            ex_reg_we   = 1'($urandom);
            ex_rd       = 4'($urandom_range(0, 3));
            ex_redirect = ($urandom_range(0, 5) == 0);
            ma_mem_en   = 1'($urandom);
            dmem_ready  = ($urandom_range(0, 3) != 0);
            step("rand", 1);
            if (m_halted && $urandom_range(0, 3) == 0) do_reset();
        end

        // Saturation of the stall counter.
        do_reset();
        set_idle();
        set_load_use();
        for (int i = 0; i < 70000; i++) step("sat", 0);
        chk("sat_cnt", stall_cycles, 16'hFFFF);
        step("sat_model", 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central stall/flush/halt controller for the five-stage pipeline (IF, ID, EX, MA, WB). It watches decode-stage operands, the EX-stage instruction, branch resolution and the data-memory handshake. Each cycle it drives the write-enable, flush and bubble controls of the PC and every pipeline register. It also owns the run/halt state machine, a memory-wait watchdog and a stall-cycle performance counter.

## Interface
Parameters:
- REG_AW, 4: register-index width.
- MEM_TIMEOUT, 15: maximum consecutive data-memory wait cycles before error.
- HLT_OPCODE, 5'b11111: halt opcode.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_opcode` in 5: opcode in ID.
- `id_rs1`, `id_rs2` in REG_AW each: source indices in ID.
- `id_need_rs1`, `id_need_rs2` in 1 each: EX_NEED_RS1 and EX_NEED_RS2 from the ControlUnit for the ID instruction.
- `ex_mem_en`, `ex_mem_wr` in 1 each: EX instruction's MA enable and write flag. 1 on `ex_mem_wr` means store. A load is `ex_mem_en & ~ex_mem_wr`.
- `ex_reg_we` in 1: EX instruction writes a register.
- `ex_rd` in REG_AW: EX destination index.
- `ex_redirect` in 1: taken BXX, JMP or JMPL resolved in EX.
- `ma_mem_en` in 1: MA instruction accesses data memory.
- `dmem_ready` in 1: data memory completes the MA access this cycle.
- `pc_en`, `ifid_en`, `idex_en`, `exma_en` out 1 each: register load enables.
- `ifid_flush` out 1: IF/ID loads a NOP.
- `idex_bubble` out 1: ID/EX loads a NOP, with all control fields zero, as for opcode 0.
- `mawb_bubble` out 1: MA/WB loads a NOP.
- `halted` out 1: core stopped.
- `mem_err` out 1: sticky watchdog error.
- `stall_cycles` out 16: saturating stall counter.

## Operation
- **States:** RUN, DRAIN, HALTED. The state encoding is private.
- **Conditions:**
  - mem_wait = `ma_mem_en & ~dmem_ready`.
  - load_use = (`ex_mem_en & ~ex_mem_wr & ex_reg_we`) and either (`id_need_rs1` and `id_rs1` == `ex_rd`) or (`id_need_rs2` and `id_rs2` == `ex_rd`).
  - is_hlt = `id_opcode` == HLT_OPCODE.
- **Priority in RUN and DRAIN:** mem_wait > `ex_redirect` > load_use > is_hlt > normal.
- **mem_wait:**
  - `pc_en`, `ifid_en`, `idex_en`, `exma_en` = 0; `mawb_bubble` = 1.
  - Redirect, load_use and halt are ignored this cycle and re-evaluated next cycle.
- **ex_redirect:**
  - All enables 1; `ifid_flush` = 1 and `idex_bubble` = 1, squashing the two younger instructions.
  - A HLT in ID is squashed, so no DRAIN is entered.
- **load_use:**
  - `pc_en` = 0, `ifid_en` = 0, `idex_en` = 1 with `idex_bubble` = 1; `exma_en` = 1.
  - Exactly one bubble is inserted; the MA→EX forwarding path covers the rest.
- **is_hlt in RUN:**
  - `pc_en` = 0, `ifid_flush` = 1, `idex_bubble` = 1. The HLT itself is not issued to EX.
  - Go to DRAIN with drain_cnt = 3.
- **DRAIN:**
  - `pc_en` = 0, `ifid_flush` = 1, `idex_bubble` = 1; `exma_en` = 1.
  - drain_cnt decrements on each cycle without mem_wait.
  - When drain_cnt = 1 and there is no mem_wait, go to HALTED.
- **HALTED:**
  - All enables 0, `ifid_flush` = `idex_bubble` = `mawb_bubble` = 1, `halted` = 1.
  - Only `rst` exits this state.
- **Normal (RUN):** all enables 1; flush and bubble outputs 0.
- **Watchdog:**
  - wait_cnt increments on each mem_wait cycle and clears on any cycle without mem_wait.
  - When wait_cnt reaches MEM_TIMEOUT while mem_wait is still high, set `mem_err` and go to HALTED on that edge.
  - `mem_err` is sticky until `rst`.
- **stall_cycles:**
  - Increments when `pc_en` = 0 and state ≠ HALTED.
  - Saturates at 16'hFFFF; no wrap-around.

## Timing
- All outputs are combinational from the current state and current inputs, valid in the same cycle. State, drain_cnt, wait_cnt, `mem_err` and `stall_cycles` update on the `clk` rising edge.
- **While `rst` = 1 (asynchronous):**
  - State RUN, counters 0, `mem_err` 0, `halted` 0.
  - All enables forced to 0; `ifid_flush`, `idex_bubble`, `mawb_bubble` forced to 1.
- First cycle after `rst` deasserts: normal RUN outputs.
- Load-use costs exactly 1 cycle; redirect costs 2 squashed slots.
- HLT in ID at cycle N gives `halted` = 1 from cycle N+4, provided there is no mem_wait.
- mem_wait during DRAIN freezes drain_cnt.
- `rst` mid-DRAIN or in HALTED returns to RUN immediately.

## Test plan
- **Load-use:** EX holds LD with `ex_rd` = 3; ID holds ADD with `id_need_rs1` = 1, `id_rs1` = 3. Expect one cycle of `pc_en` = 0, `ifid_en` = 0, `idex_bubble` = 1, then normal outputs. `stall_cycles` = 1. Repeat with `id_need_rs1` = 0: no stall.
- **Redirect vs hazards:** `ex_redirect` = 1 with load_use and is_hlt also true. Expect `ifid_flush` = `idex_bubble` = 1, `pc_en` = 1, state stays RUN, `halted` stays 0.
- **Memory wait:** `ma_mem_en` = 1, `dmem_ready` low for 4 cycles. Expect 4 frozen cycles with `mawb_bubble` = 1, then release. `stall_cycles` = 4; `mem_err` = 0.
- **Watchdog:** `dmem_ready` held low for MEM_TIMEOUT = 15 cycles. Expect `mem_err` = 1 and `halted` = 1 after the 15th cycle. Both stay set until `rst`, which clears them asynchronously.
- **Halt drain:** HLT in ID at cycle 0 gives `halted` = 1 at cycle 4. Insert one mem_wait cycle during DRAIN: `halted` moves to cycle 5, and `stall_cycles` stops incrementing once halted.
- **Counter saturation:** force load_use continuously for 70000 cycles. `stall_cycles` reads 16'hFFFF.
